// File: rtl/vx_tcu_uop_seq.sv
// Tensor-core micro-op sequencer: expands one WMMA instruction into
// M_STEPS * N_STEPS * nk_eff micro-ops, k innermost, then n, then m.
module vx_tcu_uop_seq #(
    parameter int unsigned M_STEPS = 2,
    parameter int unsigned N_STEPS = 4,
    parameter int unsigned K_STEPS = 4,
    parameter int unsigned RA      = 0,
    parameter int unsigned RB      = 8,
    parameter int unsigned RC      = 24,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       in_fmt_s,
    input  logic [3:0]       in_fmt_d,
    input  logic [3:0]       in_nk,
    input  logic             in_zero_c,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_fmt_s,
    output logic [3:0]       out_fmt_d,
    output logic [2:0]       out_step_m,
    output logic [2:0]       out_step_n,
    output logic [2:0]       out_step_k,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rs3,
    output logic [4:0]       out_rd,
    output logic             out_clr,
    output logic             out_first,
    output logic             out_last,
    output logic             out_fmt_err
);

    localparam logic [2:0] M_LAST = 3'(M_STEPS - 1);
    localparam logic [2:0] N_LAST = 3'(N_STEPS - 1);
    localparam logic [3:0] K_MAX  = 4'(K_STEPS);
    localparam logic [7:0] RA8    = 8'(RA);
    localparam logic [7:0] RB8    = 8'(RB);
    localparam logic [7:0] RC8    = 8'(RC);
    localparam logic [7:0] KS8    = 8'(K_STEPS);
    localparam logic [7:0] NS8    = 8'(N_STEPS);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [2:0]       m_q;
    logic [2:0]       n_q;
    logic [2:0]       k_q;
    logic [3:0]       nk_q;
    logic             zero_c_q;
    logic             fmt_err_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       fmt_s_q;
    logic [3:0]       fmt_d_q;

    logic       k_last;
    logic       n_last;
    logic       m_last;
    logic       out_fire;
    logic       last_fire;
    logic       accept;
    logic [3:0] in_nk_eff;
    logic [7:0] rs1_full;
    logic [7:0] rs2_full;
    logic [7:0] rc_full;

    // Format IDs the datapath understands; anything else is flagged, not rejected.
    function automatic logic fmt_ok(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: fmt_ok = 1'b1;
            default:                         fmt_ok = 1'b0;
        endcase
    endfunction

    // Handshake decode and loop-boundary detection
    always_comb begin
        k_last    = ({1'b0, k_q} == (nk_q - 4'd1));
        n_last    = (n_q == N_LAST);
        m_last    = (m_q == M_LAST);
        out_fire  = (state_q == StBusy) && out_ready;
        last_fire = out_fire && k_last && n_last && m_last;
        // Ready again on the last handshake so the next instruction follows with no bubble
        in_ready  = (state_q == StIdle) || last_fire;
        accept    = in_valid && in_ready;
        in_nk_eff = (in_nk == 4'd0 || in_nk > K_MAX) ? K_MAX : in_nk;
    end

    // Sequencer state: latch instruction on accept, step counters on each uop handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            m_q       <= 3'd0;
            n_q       <= 3'd0;
            k_q       <= 3'd0;
            nk_q      <= 4'd0;
            zero_c_q  <= 1'b0;
            fmt_err_q <= 1'b0;
            tag_q     <= '0;
            fmt_s_q   <= 4'd0;
            fmt_d_q   <= 4'd0;
        end else if (accept) begin
            state_q   <= StBusy;
            m_q       <= 3'd0;
            n_q       <= 3'd0;
            k_q       <= 3'd0;
            nk_q      <= in_nk_eff;
            zero_c_q  <= in_zero_c;
            fmt_err_q <= !(fmt_ok(in_fmt_s) && fmt_ok(in_fmt_d));
            tag_q     <= in_tag;
            fmt_s_q   <= in_fmt_s;
            fmt_d_q   <= in_fmt_d;
        end else if (last_fire) begin
            state_q <= StIdle;
            m_q     <= 3'd0;
            n_q     <= 3'd0;
            k_q     <= 3'd0;
        end else if (out_fire) begin
            if (k_last) begin
                k_q <= 3'd0;
                if (n_last) begin
                    n_q <= 3'd0;
                    m_q <= m_q + 3'd1;
                end else begin
                    n_q <= n_q + 3'd1;
                end
            end else begin
                k_q <= k_q + 3'd1;
            end
        end
    end

    // Register-index arithmetic done in 8 bits, then wrapped to the 32-entry file
    always_comb begin
        rs1_full = RA8 + 8'(m_q) * KS8 + 8'(k_q);
        rs2_full = RB8 + 8'(n_q) * KS8 + 8'(k_q);
        rc_full  = RC8 + 8'(m_q) * NS8 + 8'(n_q);
    end

    // Payload is a pure function of registered state, so it holds while stalled
    always_comb begin
        out_valid   = (state_q == StBusy);
        out_tag     = tag_q;
        out_fmt_s   = fmt_s_q;
        out_fmt_d   = fmt_d_q;
        out_step_m  = m_q;
        out_step_n  = n_q;
        out_step_k  = k_q;
        out_rs1     = rs1_full[4:0];
        out_rs2     = rs2_full[4:0];
        out_rs3     = rc_full[4:0];
        out_rd      = rc_full[4:0];
        out_clr     = zero_c_q && (k_q == 3'd0);
        out_first   = (m_q == 3'd0) && (n_q == 3'd0) && (k_q == 3'd0);
        out_last    = m_last && n_last && k_last;
        out_fmt_err = fmt_err_q;
    end

endmodule

// File: tb/tb_vx_tcu_uop_seq.sv
// Self-checking bench for vx_tcu_uop_seq (default parameters) using an
// expected-uop queue filled on each instruction acceptance.
module tb_vx_tcu_uop_seq;

    typedef logic [48:0] uop_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_tag;
    logic [3:0] in_fmt_s;
    logic [3:0] in_fmt_d;
    logic [3:0] in_nk;
    logic       in_zero_c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_tag;
    logic [3:0] out_fmt_s;
    logic [3:0] out_fmt_d;
    logic [2:0] out_step_m;
    logic [2:0] out_step_n;
    logic [2:0] out_step_k;
    logic [4:0] out_rs1;
    logic [4:0] out_rs2;
    logic [4:0] out_rs3;
    logic [4:0] out_rd;
    logic       out_clr;
    logic       out_first;
    logic       out_last;
    logic       out_fmt_err;

    int total = 0;
    int bad   = 0;

    uop_t q[$];
    uop_t got;
    uop_t exp_u;
    logic hs_out, hs_in, ov, ir;
    logic [4:0] g_rs1, g_rs2, g_rd;
    logic [2:0] g_k;
    logic g_clr, g_first, g_last, g_err;

    vx_tcu_uop_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .in_fmt_s   (in_fmt_s),
        .in_fmt_d   (in_fmt_d),
        .in_nk      (in_nk),
        .in_zero_c  (in_zero_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_fmt_s  (out_fmt_s),
        .out_fmt_d  (out_fmt_d),
        .out_step_m (out_step_m),
        .out_step_n (out_step_n),
        .out_step_k (out_step_k),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rs3    (out_rs3),
        .out_rd     (out_rd),
        .out_clr    (out_clr),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_fmt_err(out_fmt_err)
    );

    always #5 clk = ~clk;

    function automatic logic fmt_good(input logic [3:0] f);
        return (f <= 4'd3) || (f >= 4'd8 && f <= 4'd12);
    endfunction

    // Reference expansion with default geometry M=2, N=4, K=4, RA=0, RB=8, RC=24
    function automatic void push_instr(input logic [7:0] tag, input logic [3:0] fs,
                                       input logic [3:0] fd, input logic [3:0] nk,
                                       input logic zc);
        int   nke;
        logic err;
        nke = (nk == 4'd0 || nk > 4'd4) ? 4 : int'(nk);
        err = !(fmt_good(fs) && fmt_good(fd));
        for (int m = 0; m < 2; m++)
            for (int n = 0; n < 4; n++)
                for (int k = 0; k < nke; k++)
                    q.push_back({tag, fs, fd, 3'(m), 3'(n), 3'(k),
                                 5'((m * 4 + k) % 32), 5'((8 + n * 4 + k) % 32),
                                 5'((24 + m * 4 + n) % 32), 5'((24 + m * 4 + n) % 32),
                                 zc && (k == 0), (m == 0 && n == 0 && k == 0),
                                 (m == 1 && n == 3 && k == nke - 1), err});
    endfunction

    // One clock: sample at negedge (inputs settled, handshake pending), resume after posedge
    task automatic tick();
        @(negedge clk);
        got     = {out_tag, out_fmt_s, out_fmt_d, out_step_m, out_step_n, out_step_k,
                   out_rs1, out_rs2, out_rs3, out_rd, out_clr, out_first, out_last, out_fmt_err};
        ov      = out_valid;
        ir      = in_ready;
        hs_out  = out_valid && out_ready && !reset;
        hs_in   = in_valid && in_ready && !reset;
        g_rs1   = out_rs1;
        g_rs2   = out_rs2;
        g_rd    = out_rd;
        g_k     = out_step_k;
        g_clr   = out_clr;
        g_first = out_first;
        g_last  = out_last;
        g_err   = out_fmt_err;
        if (hs_in) push_instr(in_tag, in_fmt_s, in_fmt_d, in_nk, in_zero_c);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] tag, input logic [3:0] fs, input logic [3:0] fd,
                         input logic [3:0] nk, input logic zc);
        in_valid  = 1'b1;
        in_tag    = tag;
        in_fmt_s  = fs;
        in_fmt_d  = fd;
        in_nk     = nk;
        in_zero_c = zc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b, want 0/1", ov, ir);
        end
        total++;
        if ($isunknown(got)) begin
            bad++;
            $display("FAIL reset_payload_x: payload=%h has X", got);
        end
        reset = 1'b0;
        tick();
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: out_valid=%b in_ready=%b, want 0/1", ov, ir);
        end
    endtask

    task automatic test_basic();
        int n = 0, c0 = 0, c1 = 0;
        offer(8'h11, 4'd1, 4'd0, 4'd4, 1'b0);
        for (int c = 0; c < 100 && n < 32; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL basic_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                if (n == 0) begin
                    c0 = c;
                    total++;
                    if ({g_rs1, g_rs2, g_rd} !== {5'd0, 5'd8, 5'd24}) begin
                        bad++;
                        $display("FAIL basic_first_regs: got %0d/%0d/%0d want 0/8/24",
                                 g_rs1, g_rs2, g_rd);
                    end
                end
                if (n == 31) begin
                    total++;
                    if ({g_rs1, g_rs2, g_rd, g_last} !== {5'd7, 5'd23, 5'd31, 1'b1}) begin
                        bad++;
                        $display("FAIL basic_last_regs: got %0d/%0d/%0d last=%b want 7/23/31/1",
                                 g_rs1, g_rs2, g_rd, g_last);
                    end
                end
                c1 = c;
                n++;
            end
        end
        total++;
        if (n != 32 || c1 - c0 != 31) begin
            bad++;
            $display("FAIL basic_count: uops=%0d span=%0d want 32/31", n, c1 - c0);
        end
        tick();
        total++;
        if (ov !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: out_valid=%b want 0", ov);
        end
    endtask

    task automatic test_zero_c();
        int n = 0, clr = 0, maxk = 0;
        offer(8'h5a, 4'd9, 4'd8, 4'd2, 1'b1);
        for (int c = 0; c < 100 && n < 16; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL zeroc_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                if (g_clr) clr++;
                if (int'(g_k) > maxk) maxk = int'(g_k);
                n++;
            end
        end
        total++;
        if (n != 16 || clr != 8 || maxk != 1) begin
            bad++;
            $display("FAIL zeroc_summary: uops=%0d clr=%0d maxk=%0d want 16/8/1", n, clr, maxk);
        end
    endtask

    task automatic test_back_to_back();
        int  n = 0, acc = 0, gaps = 0;
        logic chk_next = 1'b0;
        offer(8'h21, 4'd1, 4'd1, 4'd2, 1'b0);
        for (int c = 0; c < 150 && n < 32; c++) begin
            tick();
            if (chk_next) begin
                chk_next = 1'b0;
                total++;
                if (!(ov && g_first)) begin
                    bad++;
                    $display("FAIL b2b_second_first: valid=%b first=%b want 1/1", ov, g_first);
                end
            end
            if (n > 0 && !ov) gaps++;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL b2b_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                n++;
            end
            if (hs_in) begin
                acc++;
                if (acc == 1) begin
                    in_tag   = 8'h22;
                    in_fmt_s = 4'd2;
                end else begin
                    in_valid = 1'b0;
                    chk_next = 1'b1;
                    total++;
                    if ({hs_out, g_last} !== 2'b11) begin
                        bad++;
                        $display("FAIL b2b_accept_on_last: hs=%b last=%b want 1/1",
                                 hs_out, g_last);
                    end
                end
            end
        end
        total++;
        if (n != 32 || gaps != 0 || acc != 2) begin
            bad++;
            $display("FAIL b2b_summary: uops=%0d gaps=%0d accepts=%0d want 32/0/2", n, gaps, acc);
        end
    endtask

    task automatic test_stall();
        int   n = 0, p = 0, stalls = 0;
        logic [3:0] pat = 4'b1001;
        logic prev_stall = 1'b0;
        uop_t prev_got = '0;
        offer(8'h33, 4'd3, 4'd0, 4'd4, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 120 && n < 32; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (prev_stall) begin
                total++;
                if (got !== prev_got) begin
                    bad++;
                    $display("FAIL stall_hold: got=%h want=%h", got, prev_got);
                end
            end
            prev_stall = ov && !out_ready;
            if (prev_stall) stalls++;
            prev_got = got;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL stall_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                n++;
            end
            if (n >= 5 && p < 4) begin
                out_ready = pat[3 - p];
                p++;
            end else begin
                out_ready = 1'b1;
            end
        end
        total++;
        if (n != 32 || stalls != 2) begin
            bad++;
            $display("FAIL stall_summary: uops=%0d stalls=%0d want 32/2", n, stalls);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, extra = 0;
        offer(8'h40, 4'd0, 4'd0, 4'd4, 1'b0);
        for (int c = 0; c < 50 && n < 10; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL rstmid_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                n++;
            end
        end
        reset = 1'b1;
        offer(8'h41, 4'd0, 4'd0, 4'd4, 1'b0);
        q.delete();
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_state: out_valid=%b in_ready=%b want 0/1", ov, ir);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ov) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL rstmid_abandon: stray uops=%0d want 0", extra);
        end
        n = 0;
        offer(8'h44, 4'd10, 4'd8, 4'd3, 1'b0);
        for (int c = 0; c < 80 && n < 24; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL rstmid_new_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                n++;
            end
        end
        total++;
        if (n != 24) begin
            bad++;
            $display("FAIL rstmid_new_count: uops=%0d want 24", n);
        end
    endtask

    task automatic test_fmt_err();
        int n = 0, errs = 0;
        offer(8'h66, 4'd5, 4'd1, 4'd4, 1'b0);
        for (int c = 0; c < 100 && n < 32; c++) begin
            tick();
            if (hs_in) in_valid = 1'b0;
            if (hs_out) begin
                total++;
                exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                if (got !== exp_u) begin
                    bad++;
                    $display("FAIL fmterr_uop%0d: got=%h want=%h", n, got, exp_u);
                end
                if (g_err) errs++;
                n++;
            end
        end
        total++;
        if (n != 32 || errs != 32) begin
            bad++;
            $display("FAIL fmterr_summary: uops=%0d errs=%0d want 32/32", n, errs);
        end
    endtask

    task automatic test_nk_clamp();
        logic [3:0] nks [2] = '{4'd0, 4'd9};
        for (int i = 0; i < 2; i++) begin
            int n = 0;
            offer(8'h70 + 8'(i), 4'd11, 4'd12, nks[i], 1'b1);
            for (int c = 0; c < 100 && n < 32; c++) begin
                tick();
                if (hs_in) in_valid = 1'b0;
                if (hs_out) begin
                    total++;
                    exp_u = (q.size() != 0) ? q.pop_front() : 'x;
                    if (got !== exp_u) begin
                        bad++;
                        $display("FAIL nkclamp%0d_uop%0d: got=%h want=%h", i, n, got, exp_u);
                    end
                    n++;
                end
            end
            tick();
            total++;
            if (n != 32 || ov !== 1'b0) begin
                bad++;
                $display("FAIL nkclamp%0d_count: uops=%0d valid_after=%b want 32/0", i, n, ov);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_tag    = 8'h00;
        in_fmt_s  = 4'd0;
        in_fmt_d  = 4'd0;
        in_nk     = 4'd0;
        in_zero_c = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_zero_c();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_fmt_err();
        test_nk_clamp();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_uops: pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
